// File: rtl/velocity_update_scheduler_if.sv
// velocity_update_scheduler_if: velocity-set request, bot handshake and shared write port.
// The master modport is the scheduler side and the slave modport is the environment side.
interface velocity_update_scheduler_if #(
   parameter int VW = 16
);
   logic          write_check;
   logic [VW-1:0] vx1_bin, vy1_bin, vx2_bin, vy2_bin, vx3_bin, vy3_bin;
   logic [2:0]    bot_rdy;
   logic          wr_valid;
   logic          wr_ready;
   logic [1:0]    wr_bot;
   logic [VW-1:0] wr_vx, wr_vy;
   logic [2:0]    pending;
   logic          busy;
   logic          overrun;
   modport master (
      input  write_check, vx1_bin, vy1_bin, vx2_bin, vy2_bin, vx3_bin, vy3_bin, bot_rdy, wr_ready,
      output wr_valid, wr_bot, wr_vx, wr_vy, pending, busy, overrun
   );
   modport slave (
      output write_check, vx1_bin, vy1_bin, vx2_bin, vy2_bin, vx3_bin, vy3_bin, bot_rdy, wr_ready,
      input  wr_valid, wr_bot, wr_vx, wr_vy, pending, busy, overrun
   );
endinterface

// File: rtl/velocity_update_scheduler.sv
// velocity_update_scheduler: settles a captured velocity set, then writes it round-robin to three bots.
// Optional VUS_OVERRUN_CNT_EN adds the saturating 8-bit overrun counter output ovr_cnt.
module velocity_update_scheduler #(
   parameter int SETTLE_CYCLES = 300,
   parameter int VW = 16
) (
   input  logic clk,
   input  logic rst,
`ifdef VUS_OVERRUN_CNT_EN
   output logic [7:0] ovr_cnt,
`endif
   velocity_update_scheduler_if.master vus
);
   localparam logic [1:0] S_IDLE = 2'd0, S_SETTLE = 2'd1, S_ARB = 2'd2, S_WRITE = 2'd3;
   localparam logic [9:0] SC = 10'(SETTLE_CYCLES);
   logic [1:0]    r_state, r_last, r_bot, w_c1, w_c2, w_gnt;
   logic [9:0]    r_cnt;
   logic [2:0]    r_pending, w_elig, w_clr;
   logic          r_wc, r_valid, r_ovr, w_edge, w_xfer, w_ovr;
   logic [VW-1:0] r_vx [3], r_vy [3], w_in_vx [3], w_in_vy [3], w_vx [3], w_vy [3], r_wvx, r_wvy;
   assign w_in_vx[0] = vus.vx1_bin;
   assign w_in_vx[1] = vus.vx2_bin;
   assign w_in_vx[2] = vus.vx3_bin;
   assign w_in_vy[0] = vus.vy1_bin;
   assign w_in_vy[1] = vus.vy2_bin;
   assign w_in_vy[2] = vus.vy3_bin;
   assign w_edge = vus.write_check & ~r_wc;
   assign w_ovr  = w_edge & (|r_pending);
   assign w_xfer = (r_state == S_WRITE) & vus.wr_ready;
   assign w_clr  = w_xfer ? (3'b001 << r_bot) : 3'b000;
   // A set arriving in the granting cycle is forwarded so the grant never uses stale data.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         w_vx[k] = w_edge ? w_in_vx[k] : r_vx[k];
         w_vy[k] = w_edge ? w_in_vy[k] : r_vy[k];
      end
   end
   assign w_elig = r_pending & vus.bot_rdy;
   assign w_c1   = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
   assign w_c2   = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
   assign w_gnt  = w_elig[w_c1] ? w_c1 : w_elig[w_c2] ? w_c2 : r_last;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_wc      <= 1'b0;
         r_pending <= '0;
         r_ovr     <= 1'b0;
         r_valid   <= 1'b0;
         r_bot     <= '0;
         r_wvx     <= '0;
         r_wvy     <= '0;
         r_last    <= 2'd2;
         for (int k = 0; k < 3; k++) begin
            r_vx[k] <= '0;
            r_vy[k] <= '0;
         end
      end else begin
         r_wc      <= vus.write_check;
         r_ovr     <= w_ovr;
         r_pending <= (r_pending & ~w_clr) | {3{w_edge}};
         if (w_edge) begin
            for (int k = 0; k < 3; k++) begin
               r_vx[k] <= w_in_vx[k];
               r_vy[k] <= w_in_vy[k];
            end
         end
         if (r_state == S_IDLE) begin
            if (w_edge) begin
               r_state <= (SETTLE_CYCLES == 0) ? S_ARB : S_SETTLE;
               r_cnt   <= '0;
            end
         end else if (r_state == S_SETTLE) begin
            if (w_edge)
               r_cnt <= '0;
            else if (r_cnt == SC)
               r_state <= S_ARB;
            else
               r_cnt <= r_cnt + 10'd1;
         end else if (r_state == S_ARB) begin
            if (|w_elig) begin
               r_state <= S_WRITE;
               r_valid <= 1'b1;
               r_bot   <= w_gnt;
               r_wvx   <= w_vx[w_gnt];
               r_wvy   <= w_vy[w_gnt];
            end else if (r_pending == 3'b000 && !w_edge)
               r_state <= S_IDLE;
         end else if (w_xfer) begin
            r_state <= S_ARB;
            r_valid <= 1'b0;
            r_last  <= r_bot;
         end
      end
   end
`ifdef VUS_OVERRUN_CNT_EN
   logic [7:0] r_ocnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ocnt <= '0;
      else if (w_ovr && r_ocnt != 8'hFF)
         r_ocnt <= r_ocnt + 8'd1;
   end
   assign ovr_cnt = r_ocnt;
`endif
   assign vus.wr_valid = r_valid;
   assign vus.wr_bot   = r_bot;
   assign vus.wr_vx    = r_wvx;
   assign vus.wr_vy    = r_wvy;
   assign vus.pending  = r_pending;
   assign vus.busy     = (r_state != S_IDLE);
   assign vus.overrun  = r_ovr;
endmodule

// File: tb/tb_velocity_update_scheduler.sv
// tb_velocity_update_scheduler: directed vectors with a queue scoreboard popped by a write-port monitor.
module tb_velocity_update_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   logic [33:0] exp_q [$];
   velocity_update_scheduler_if #(.VW(16)) u_if ();
`ifdef VUS_OVERRUN_CNT_EN
   logic [7:0] ovr_cnt;
   velocity_update_scheduler #(.SETTLE_CYCLES(4), .VW(16)) dut (.clk(clk), .rst(rst), .ovr_cnt(ovr_cnt), .vus(u_if));
`else
   velocity_update_scheduler #(.SETTLE_CYCLES(4), .VW(16)) dut (.clk(clk), .rst(rst), .vus(u_if));
`endif
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   task automatic set_v(input logic [15:0] x1, x2, x3, y1, y2, y3);
      u_if.vx1_bin = x1; u_if.vx2_bin = x2; u_if.vx3_bin = x3;
      u_if.vy1_bin = y1; u_if.vy2_bin = y2; u_if.vy3_bin = y3;
   endtask
   task automatic push(input logic [1:0] b, input logic [15:0] x, input logic [15:0] y);
      exp_q.push_back({b, x, y});
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic pulse_wc();
      u_if.write_check = 1'b1;
      tick();
      u_if.write_check = 1'b0;
   endtask
   task automatic wait_idle(input string name);
      int n = 0;
      while (u_if.busy && n < 200) begin
         tick();
         n++;
      end
      chk(name, {63'd0, u_if.busy}, 64'd0);
   endtask
   task automatic wait_valid(input string name);
      int n = 0;
      while (!u_if.wr_valid && n < 40) begin
         tick();
         n++;
      end
      chk(name, {63'd0, u_if.wr_valid}, 64'd1);
   endtask
   // Monitor: every accepted transfer must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && u_if.wr_valid && u_if.wr_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_xfer actual=%0h required=none", {u_if.wr_bot, u_if.wr_vx, u_if.wr_vy});
         end else
            chk("xfer", {30'd0, u_if.wr_bot, u_if.wr_vx, u_if.wr_vy}, {30'd0, exp_q.pop_front()});
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      u_if.write_check = 1'b0;
      u_if.bot_rdy = 3'b111;
      u_if.wr_ready = 1'b1;
      set_v(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      repeat (2) tick();
      chk("rst_valid", {63'd0, u_if.wr_valid}, 64'd0);
      chk("rst_out", {30'd0, u_if.wr_bot, u_if.wr_vx, u_if.wr_vy}, 64'd0);
      chk("rst_pending", {61'd0, u_if.pending}, 64'd0);
      chk("rst_busy_ovr", {62'd0, u_if.busy, u_if.overrun}, 64'd0);
      rst = 1'b0;
      tick();
      // Basic set: latency and in-order round robin from bot 0.
      set_v(16'h0800, 16'h0010, 16'h0C00, 16'h0100, 16'h0200, 16'h0300);
      push(2'd0, 16'h0800, 16'h0100);
      push(2'd1, 16'h0010, 16'h0200);
      push(2'd2, 16'h0C00, 16'h0300);
      pulse_wc();
      chk("capture_pending", {61'd0, u_if.pending}, 64'd7);
      chk("capture_busy", {63'd0, u_if.busy}, 64'd1);
      n = 0;
      while (n < 20) begin
         tick();
         n++;
         if (u_if.wr_valid) break;
      end
      chk("first_valid_edge", 64'(n), 64'd6);
      wait_idle("idle_after_basic");
      chk("pending_after_basic", {61'd0, u_if.pending}, 64'd0);
      // Bot 1 not ready: bots 0 and 2 first, bot 1 after its ready rises.
      u_if.bot_rdy = 3'b101;
      set_v(16'h1000, 16'h1100, 16'h1200, 16'h2000, 16'h2100, 16'h2200);
      push(2'd0, 16'h1000, 16'h2000);
      push(2'd2, 16'h1200, 16'h2200);
      push(2'd1, 16'h1100, 16'h2100);
      pulse_wc();
      n = 0;
      while (u_if.pending != 3'b010 && n < 40) begin
         tick();
         n++;
      end
      repeat (10) tick();
      chk("rdy_wait_pending", {61'd0, u_if.pending}, 64'd2);
      chk("rdy_wait_valid", {63'd0, u_if.wr_valid}, 64'd0);
      u_if.bot_rdy = 3'b111;
      tick();
      chk("rdy_grant", {61'd0, u_if.wr_valid, u_if.wr_bot}, {61'd0, 1'b1, 2'd1});
      tick();
      chk("rdy_written", {61'd0, u_if.pending}, 64'd0);
      wait_idle("idle_after_rdy");
      // Stalled write port: outputs hold, then a single transfer.
      u_if.wr_ready = 1'b0;
      set_v(16'h0A01, 16'h0A02, 16'h0A03, 16'h0B01, 16'h0B02, 16'h0B03);
      push(2'd2, 16'h0A03, 16'h0B03);
      push(2'd0, 16'h0A01, 16'h0B01);
      push(2'd1, 16'h0A02, 16'h0B02);
      pulse_wc();
      wait_valid("stall_valid");
      for (int i = 0; i < 5; i++) begin
         chk("stall_hold", {45'd0, u_if.wr_valid, u_if.wr_bot, u_if.wr_vx}, {45'd0, 1'b1, 2'd2, 16'h0A03});
         tick();
      end
      u_if.wr_ready = 1'b1;
      tick();
      chk("single_xfer", {61'd0, u_if.pending}, 64'd3);
      wait_idle("idle_after_stall");
      // Second set arrives in ARB: one overrun pulse, bot 1 gets the new word.
      set_v(16'h0111, 16'h0010, 16'h0333, 16'h0444, 16'h0555, 16'h0666);
      pulse_wc();
      chk("no_ovr_first", {63'd0, u_if.overrun}, 64'd0);
      repeat (5) tick();
      chk("arb_no_valid", {63'd0, u_if.wr_valid}, 64'd0);
      u_if.vx2_bin = 16'h0020;
      push(2'd2, 16'h0333, 16'h0666);
      push(2'd0, 16'h0111, 16'h0444);
      push(2'd1, 16'h0020, 16'h0555);
      pulse_wc();
      chk("ovr_pulse", {63'd0, u_if.overrun}, 64'd1);
      tick();
      chk("ovr_one_cycle", {63'd0, u_if.overrun}, 64'd0);
      wait_idle("idle_after_ovr");
      // Reset mid-write drops everything; the next set starts at bot 0.
      u_if.wr_ready = 1'b0;
      set_v(16'h7777, 16'h7777, 16'h7777, 16'h7777, 16'h7777, 16'h7777);
      pulse_wc();
      wait_valid("pre_rst_valid");
      chk("pre_rst_bot", {62'd0, u_if.wr_bot}, 64'd2);
      #3 rst = 1'b1;
      #1;
      chk("rst_async_valid", {63'd0, u_if.wr_valid}, 64'd0);
      chk("rst_async_pending", {61'd0, u_if.pending}, 64'd0);
      repeat (2) tick();
      rst = 1'b0;
      u_if.wr_ready = 1'b1;
      set_v(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006);
      push(2'd0, 16'h0001, 16'h0004);
      push(2'd1, 16'h0002, 16'h0005);
      push(2'd2, 16'h0003, 16'h0006);
      tick();
      pulse_wc();
      wait_idle("idle_after_rst");
      // New set coinciding with a transfer keeps that bot's pending bit.
      u_if.wr_ready = 1'b0;
      set_v(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606);
      pulse_wc();
      wait_valid("collide_valid");
      push(2'd0, 16'h0101, 16'h0404);
      push(2'd1, 16'h0F02, 16'h0E02);
      push(2'd2, 16'h0F03, 16'h0E03);
      push(2'd0, 16'h0F01, 16'h0E01);
      set_v(16'h0F01, 16'h0F02, 16'h0F03, 16'h0E01, 16'h0E02, 16'h0E03);
      u_if.wr_ready = 1'b1;
      pulse_wc();
      chk("collide_pending", {61'd0, u_if.pending}, 64'd7);
      chk("collide_ovr", {63'd0, u_if.overrun}, 64'd1);
      wait_idle("idle_after_collide");
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef VUS_OVERRUN_CNT_EN
      chk("ovr_cnt", {56'd0, ovr_cnt}, 64'd1);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/velocity_update_scheduler.md
VELOCITY_UPDATE_SCHEDULER -- requirements
Module: velocity_update_scheduler

Interface
REQ-001 Parameter SETTLE_CYCLES, default 300; idle cycles between a velocity-set capture and the first write arbitration (range 0..1023).
REQ-002 Parameter VW, default 16; velocity word width, unsigned fixed point with 11 fractional bits.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 write_check  input  1  level; a rising edge requests a new velocity set.
REQ-006 vx1_bin, vy1_bin, vx2_bin, vy2_bin, vx3_bin, vy3_bin  input  VW each  velocity set for bots 1..3.
REQ-007 bot_rdy  input  3  bit i high = bot i+1 has consumed its previous update ("r" state).
REQ-008 wr_valid  output  1  shared write port carries a valid update.
REQ-009 wr_ready  input  1  write port accepts; a transfer occurs when wr_valid and wr_ready are both high on a rising edge.
REQ-010 wr_bot  output  2  target bot index, 0..2.
REQ-011 wr_vx, wr_vy  output  VW each  velocity pair for wr_bot.
REQ-012 pending  output  3  per-bot update outstanding.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 overrun  output  1  one-cycle pulse when a new set arrives while any pending bit is set.

Function
REQ-015 The block SHALL detect the write_check rising edge synchronously: sampled high with the previous registered sample low.
REQ-016 On an edge, the block SHALL latch all six inputs into shadow registers and set pending to 3'b111 on the same clock edge.
REQ-017 The FSM SHALL have states IDLE, SETTLE, ARB, and WRITE; IDLE->SETTLE on an edge, or IDLE->ARB when SETTLE_CYCLES=0.
REQ-018 SETTLE SHALL count exactly SETTLE_CYCLES cycles and then go to ARB.
REQ-019 ARB SHALL grant round-robin among bots with pending&bot_rdy set, starting at the bot after the last granted one, and SHALL go to WRITE in the next cycle with wr_bot, wr_vx and wr_vy loaded from the shadow registers.
REQ-020 ARB with pending nonzero and no eligible bot SHALL stay in ARB; ARB with pending==0 SHALL go to IDLE.
REQ-021 WRITE SHALL hold wr_valid, wr_bot, wr_vx and wr_vy stable until the transfer; on the transfer it SHALL clear the granted pending bit, record the last grant, and return to ARB.
REQ-022 Latency: with SETTLE_CYCLES=N>0, all bot_rdy high and wr_ready high, the first wr_valid SHALL appear on the (N+2)th rising edge after the edge that detects write_check, and the three transfers SHALL complete within 6 further cycles.
REQ-023 An edge while busy SHALL update the shadow registers, OR 3'b111 into pending, and pulse overrun if pending was nonzero; in SETTLE the counter SHALL restart; in WRITE the in-flight outputs SHALL NOT change.
REQ-024 An edge in the same cycle as a WRITE transfer SHALL leave the transferred bot's pending bit set, because the set takes priority over the clear.
REQ-025 bot_rdy changes SHALL affect only ARB decisions and SHALL NOT abort a WRITE.

Reset
REQ-026 Reset SHALL force state=IDLE, wr_valid=0, wr_bot=0, wr_vx=0, wr_vy=0, pending=0, busy=0, overrun=0, shadow registers=0, last grant=2 (bot 0 first), and the edge-detect register=0.
REQ-027 Reset asserted mid-WRITE SHALL drop wr_valid immediately and discard all pending updates.

Configuration
REQ-028 Macro VUS_OVERRUN_CNT_EN: when defined, the block SHALL add an 8-bit output ovr_cnt that increments on each overrun pulse, saturates at 255, and resets to 0; when undefined, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 SETTLE_CYCLES=4, all bot_rdy=1, wr_ready=1, write_check edge with vx1_bin=16'h0800 -> wr_valid on edge 6, wr_bot sequence 0,1,2, first wr_vx=16'h0800, then pending=0 and state IDLE.
REQ-030 bot_rdy=3'b101 then bot_rdy[1] rises 10 cycles later -> bots 0 and 2 are written first; bot 1 is written 2 cycles after its bot_rdy rises.
REQ-031 wr_ready held low for 5 cycles in WRITE -> wr_valid, wr_bot and wr_vx stay stable for all 5 cycles; a single transfer follows.
REQ-032 Second write_check edge during ARB with vx2_bin changed 16'h0010->16'h0020 -> overrun pulses once and bot 1 receives 16'h0020.
REQ-033 rst asserted during WRITE -> wr_valid=0 and pending=0 asynchronously; the next edge restarts from bot 0.
REQ-034 With VUS_OVERRUN_CNT_EN, 300 overrun events -> ovr_cnt=255.
